bcd_serial_alu: RTL

Multi-digit packed-BCD add/subtract controller. It streams a DIGITS-wide operand pair one digit per clock through a single-digit BCD adder stage, carrying the decimal carry/borrow between cycles. For subtraction with a negative result it runs a second correction pass, so the output is always a magnitude plus a sign. It sits between a register/keypad front end and the seven-segment display decoders, extending the single-digit add/subtract datapath to full multi-digit numbers.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_add.sv | 22 ++
 rtl/bcd_serial_alu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial multi-digit BCD add/subtract unit.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam logic       OP_ADD  = 1'b0;
   localparam logic       OP_SUB  = 1'b1;

   // Nine's complement of one decimal digit.
   function automatic bcd_digit_t nines(input bcd_digit_t d);
      return BCD_MAX - d;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: s = (x + y + cin) mod 10, cout when the raw sum exceeds 9.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] raw;
   logic [4:0] adj;

   always_comb begin
      raw  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      adj  = raw - 5'd10;
      cout = (raw > {1'b0, BCD_MAX});
      s    = cout ? adj[3:0] : raw[3:0];
   end

endmodule

// File: rtl/bcd_serial_alu.sv
// Digit-serial packed-BCD add/subtract; a negative difference gets a second
// ten's-complement pass so the result is always magnitude plus sign.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one operand digit per cycle through the shared digit adder
// FIX   | ten's complement of the result for a negative difference
// DONE  | one-cycle done pulse, then back to IDLE
module bcd_serial_alu
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  op,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  carry_out,
   output logic                  neg,
   output logic                  err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q;
   logic                     carry_q;
   logic                     op_q;
   logic [DIGITS-1:0][3:0]   a_q, b_q, res_q;
   logic                     carry_out_q, neg_q, err_q;

   logic                     bad_digit;
   logic                     last;
   bcd_digit_t               add_x, add_y, add_s;
   logic                     add_cout;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) bad_digit = 1'b1;
      end
   end

   assign last = (idx_q == LAST_IDX);

   // One adder serves both passes; FIX adds 0 to the nine's complement of the result digit.
   always_comb begin
      if (state_q == FIX) begin
         add_x = 4'd0;
         add_y = nines(res_q[idx_q]);
      end else begin
         add_x = a_q[idx_q];
         add_y = (op_q == OP_SUB) ? nines(b_q[idx_q]) : b_q[idx_q];
      end
   end

   bcd_digit_add u_digit_add (
      .x    (add_x),
      .y    (add_y),
      .cin  (carry_q),
      .s    (add_s),
      .cout (add_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = bad_digit ? DONE : RUN;
         RUN:  if (last)  state_d = (op_q == OP_SUB && !add_cout) ? FIX : DONE;
         FIX:  if (last)  state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q       <= '0;
         carry_q     <= 1'b0;
         op_q        <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         carry_out_q <= 1'b0;
         neg_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               a_q         <= a;
               b_q         <= b;
               op_q        <= op;
               idx_q       <= '0;
               carry_q     <= op;
               res_q       <= '0;
               carry_out_q <= 1'b0;
               neg_q       <= 1'b0;
               err_q       <= bad_digit;
            end
            RUN: begin
               res_q[idx_q] <= add_s;
               carry_q      <= add_cout;
               idx_q        <= last ? '0 : idx_q + 1'b1;
               if (last) begin
                  if (op_q == OP_ADD) begin
                     carry_out_q <= add_cout;
                  end else if (!add_cout) begin
                     neg_q   <= 1'b1;
                     carry_q <= 1'b1;
                  end
               end
            end
            FIX: begin
               res_q[idx_q] <= add_s;
               carry_q      <= add_cout;
               idx_q        <= last ? '0 : idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result    = res_q;
   assign carry_out = carry_out_q;
   assign neg       = neg_q;
   assign err       = err_q;

endmodule
